// File: rtl/clk_ratio_mon_if.sv
// Signal bundle between a divided-clock source and its ratio monitor.
// master: side driving clk_div/en; slave: the monitor reporting measurements.
interface clk_ratio_mon_if #(
  parameter int unsigned CW = 8
);
  logic          clk_div;
  logic          en;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          period_vld;
  logic          locked;
  logic          err;
  logic          timeout;
  logic [7:0]    err_cnt;

  modport master (
    output clk_div, en,
    input  period, high_time, period_vld, locked, err, timeout, err_cnt
  );

  modport slave (
    input  clk_div, en,
    output period, high_time, period_vld, locked, err, timeout, err_cnt
  );
endinterface

// File: rtl/clk_ratio_mon.sv
// Divided-clock ratio checker: measures period/high time of clk_div in clk_in cycles.
// Optional duty-cycle check enabled by defining CLK_RATIO_MON_DUTY_CHECK_EN.
module clk_ratio_mon #(
  parameter int unsigned N        = 8,
  parameter int unsigned TOL      = 0,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TIMEOUT  = 32,
  parameter int unsigned CW       = 8
) (
  input  logic          clk_in,
  input  logic          rstn,
  clk_ratio_mon_if.slave mon
);

  localparam int unsigned   GW    = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [CW-1:0] TO_CW = CW'(TIMEOUT);
  localparam logic [GW-1:0] LOCK_G = GW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, SYNC, MEAS} state_t;

  state_t        state_q, state_d;
  logic          s1, s2, s3;
  logic          rise_p, fall_p;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0] hi_q, hi_d;
  logic [GW-1:0] good_q, good_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_q, high_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic          locked_q, locked_d;
  logic          to_q, to_d;
  logic [7:0]    ecnt_q, ecnt_d, ecnt_inc;
  logic          duty_ok, period_good, to_hit;

  function automatic logic in_tol(input logic [CW-1:0] v, input int unsigned tgt);
    int unsigned v32;
    v32 = 32'(v);
    if (v32 >= tgt) return (v32 - tgt) <= TOL;
    else            return (tgt - v32) <= TOL;
  endfunction

  assign rise_p   = s2 & ~s3;
  assign fall_p   = ~s2 & s3;
  assign cnt_inc  = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
  assign ecnt_inc = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;

`ifdef CLK_RATIO_MON_DUTY_CHECK_EN
  assign duty_ok = in_tol(hi_q, N / 2);
`else
  assign duty_ok = 1'b1;
`endif

  // cnt_inc is the period being closed, since cnt restarts at 0 after each rise
  assign period_good = in_tol(cnt_inc, N) && duty_ok;

  // rise_p takes priority over the timeout threshold; SYNC only times out once
  assign to_hit = mon.en && !rise_p && (cnt_q == TO_CW) &&
                  ((state_q == MEAS) || ((state_q == SYNC) && !to_q));

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= mon.clk_div;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      good_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      to_q     <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      good_q   <= good_d;
      period_q <= period_d;
      high_q   <= high_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      to_q     <= to_d;
      ecnt_q   <= ecnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    good_d   = good_q;
    period_d = period_q;
    high_d   = high_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;
    to_d     = to_q;
    ecnt_d   = ecnt_q;

    if (!mon.en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      hi_d     = '0;
      good_d   = '0;
      locked_d = 1'b0;
      to_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SYNC;
          cnt_d   = '0;
          hi_d    = '0;
        end
        SYNC: begin
          if (rise_p) begin
            state_d = MEAS;
            cnt_d   = '0;
            hi_d    = '0;
            to_d    = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        MEAS: begin
          if (rise_p) begin
            cnt_d    = '0;
            hi_d     = '0;
            period_d = cnt_inc;
            high_d   = hi_q;
            vld_d    = 1'b1;
            if (period_good) begin
              if (good_q != LOCK_G) good_d = good_q + 1'b1;
              locked_d = (good_d == LOCK_G);
            end else begin
              err_d    = 1'b1;
              good_d   = '0;
              locked_d = 1'b0;
              ecnt_d   = ecnt_inc;
            end
          end else begin
            cnt_d = cnt_inc;
            if (fall_p) hi_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase

      if (to_hit) begin
        state_d  = SYNC;
        cnt_d    = '0;
        to_d     = 1'b1;
        err_d    = 1'b1;
        ecnt_d   = ecnt_inc;
        locked_d = 1'b0;
        good_d   = '0;
      end
    end
  end

  assign mon.period     = period_q;
  assign mon.high_time  = high_q;
  assign mon.period_vld = vld_q;
  assign mon.locked     = locked_q;
  assign mon.err        = err_q;
  assign mon.timeout    = to_q;
  assign mon.err_cnt    = ecnt_q;

endmodule

// File: tb/tb_clk_ratio_mon.sv
// Directed bench for clk_ratio_mon: lock, ratio change, timeout, duty, enable, reset, saturation.
module tb_clk_ratio_mon;

`ifdef CLK_RATIO_MON_DUTY_CHECK_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rstn;
  always #5 clk_in = ~clk_in;

  clk_ratio_mon_if #(.CW(8)) if0 ();
  clk_ratio_mon_if #(.CW(8)) if1 ();

  clk_ratio_mon #(.N(8), .TOL(0), .LOCK_CNT(4), .TIMEOUT(32), .CW(8)) u0 (
    .clk_in(clk_in), .rstn(rstn), .mon(if0)
  );
  clk_ratio_mon #(.N(8), .TOL(0), .LOCK_CNT(4), .TIMEOUT(255), .CW(8)) u1 (
    .clk_in(clk_in), .rstn(rstn), .mon(if1)
  );

  int checks = 0;
  int errors = 0;

  int q_per[$];
  int q_hi[$];
  int q_ecnt[$];
  bit q_lock[$];
  bit q_err[$];
  int nvld = 0;
  int nerr = 0;

  always @(negedge clk_in) begin
    if (if0.period_vld === 1'b1) begin
      q_per.push_back(int'(if0.period));
      q_hi.push_back(int'(if0.high_time));
      q_ecnt.push_back(int'(if0.err_cnt));
      q_lock.push_back(if0.locked === 1'b1);
      q_err.push_back(if0.err === 1'b1);
      nvld++;
    end
    if (if0.err === 1'b1) nerr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drv(input int hi, input int lo);
    if0.clk_div = 1'b1;
    repeat (hi) @(negedge clk_in);
    if0.clk_div = 1'b0;
    repeat (lo) @(negedge clk_in);
  endtask

  task automatic drv1(input int hi, input int lo);
    if1.clk_div = 1'b1;
    repeat (hi) @(negedge clk_in);
    if1.clk_div = 1'b0;
    repeat (lo) @(negedge clk_in);
  endtask

  initial begin
    int base, nv0, ne0, exp_ecnt;
    rstn = 1'b0;
    if0.clk_div = 1'b0;
    if0.en = 1'b0;
    if1.clk_div = 1'b0;
    if1.en = 1'b0;
    repeat (3) @(negedge clk_in);

    // reset values
    chk("rst_period", 32'(if0.period), 0);
    chk("rst_high", 32'(if0.high_time), 0);
    chk("rst_vld", 32'(if0.period_vld), 0);
    chk("rst_locked", 32'(if0.locked), 0);
    chk("rst_err", 32'(if0.err), 0);
    chk("rst_timeout", 32'(if0.timeout), 0);
    chk("rst_errcnt", 32'(if0.err_cnt), 0);

    rstn = 1'b1;
    if0.en = 1'b1;
    repeat (2) @(negedge clk_in);

    // steady ratio 8, 4 high / 4 low
    repeat (6) drv(4, 4);
    if0.clk_div = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("lat_vld_early", 32'(if0.period_vld), 0);
    @(negedge clk_in);
    chk("lat_vld", 32'(if0.period_vld), 1);
    @(negedge clk_in);
    if0.clk_div = 1'b0;
    repeat (4) @(negedge clk_in);
    chk("lock_nvld", 32'(nvld), 6);
    chk("lock_per0", 32'(q_per[0]), 8);
    chk("lock_hi0", 32'(q_hi[0]), 4);
    chk("lock_per5", 32'(q_per[5]), 8);
    chk("lock_at3", 32'(q_lock[2]), 0);
    chk("lock_at4", 32'(q_lock[3]), 1);
    chk("lock_nerr", 32'(nerr), 0);

    // ratio change to 10
    base = q_per.size();
    repeat (4) drv(5, 5);
    chk("r10_first_per", 32'(q_per[base]), 8);
    chk("r10_first_lock", 32'(q_lock[base]), 1);
    chk("r10_per", 32'(q_per[base+1]), 10);
    chk("r10_err", 32'(q_err[base+1]), 1);
    chk("r10_lock", 32'(q_lock[base+1]), 0);
    chk("r10_ecnt1", 32'(q_ecnt[base+1]), 1);
    chk("r10_ecnt2", 32'(q_ecnt[base+2]), 2);
    chk("r10_ecnt3", 32'(q_ecnt[base+3]), 3);
    chk("r10_nerr", 32'(nerr), 3);

    // relock at 8, then stop the clock
    base = q_per.size();
    repeat (5) drv(4, 4);
    chk("rl_per0", 32'(q_per[base]), 10);
    chk("rl_ecnt0", 32'(q_ecnt[base]), 4);
    chk("rl_lock", 32'(q_lock[base+4]), 1);
    ne0 = nerr;
    repeat (27) @(negedge clk_in);
    chk("to_early", 32'(if0.timeout), 0);
    @(negedge clk_in);
    chk("to_set", 32'(if0.timeout), 1);
    chk("to_err", 32'(if0.err), 1);
    chk("to_lock", 32'(if0.locked), 0);
    chk("to_ecnt", 32'(if0.err_cnt), 5);
    repeat (10) @(negedge clk_in);
    chk("to_one_err", 32'(nerr - ne0), 1);
    chk("to_hold", 32'(if0.timeout), 1);

    // restart after timeout
    nv0 = nvld;
    base = q_per.size();
    drv(4, 4);
    chk("rs_to_clr", 32'(if0.timeout), 0);
    chk("rs_no_vld", 32'(nvld - nv0), 0);
    repeat (4) drv(4, 4);
    chk("rs_lock3", 32'(q_lock[base+2]), 0);
    chk("rs_lock4", 32'(q_lock[base+3]), 1);
    chk("rs_locked", 32'(if0.locked), 1);
    chk("rs_ecnt", 32'(if0.err_cnt), 5);

    // duty 3 high / 5 low
    ne0 = nerr;
    repeat (6) drv(3, 5);
    exp_ecnt = DUTY ? 10 : 5;
    chk("duty_hi", 32'(if0.high_time), 3);
    chk("duty_per", 32'(if0.period), 8);
    chk("duty_nerr", 32'(nerr - ne0), DUTY ? 5 : 0);
    chk("duty_lock", 32'(if0.locked), DUTY ? 0 : 1);
    chk("duty_ecnt", 32'(if0.err_cnt), 32'(exp_ecnt));

    // relock, then drop en mid-period
    repeat (5) drv(4, 4);
    exp_ecnt = DUTY ? 11 : 5;
    chk("en_pre_lock", 32'(if0.locked), 1);
    if0.clk_div = 1'b1;
    repeat (2) @(negedge clk_in);
    if0.en = 1'b0;
    @(negedge clk_in);
    chk("en_lock", 32'(if0.locked), 0);
    chk("en_per", 32'(if0.period), 8);
    chk("en_high", 32'(if0.high_time), 4);
    chk("en_ecnt", 32'(if0.err_cnt), 32'(exp_ecnt));
    chk("en_vld", 32'(if0.period_vld), 0);
    if0.clk_div = 1'b0;
    @(negedge clk_in);
    if0.en = 1'b1;
    repeat (40) @(negedge clk_in);
    chk("en_sync_to", 32'(if0.timeout), 1);
    if0.en = 1'b0;
    @(negedge clk_in);
    chk("en_to_clr", 32'(if0.timeout), 0);
    chk("en_ecnt2", 32'(if0.err_cnt), 32'(exp_ecnt + 1));
    chk("en_per2", 32'(if0.period), 8);

    // asynchronous reset mid-period
    if0.en = 1'b1;
    repeat (2) @(negedge clk_in);
    repeat (3) drv(4, 4);
    if0.clk_div = 1'b1;
    repeat (2) @(negedge clk_in);
    #2 rstn = 1'b0;
    #1;
    chk("arst_period", 32'(if0.period), 0);
    chk("arst_high", 32'(if0.high_time), 0);
    chk("arst_ecnt", 32'(if0.err_cnt), 0);
    chk("arst_flags", 32'({if0.period_vld, if0.locked, if0.err, if0.timeout}), 0);
    @(negedge clk_in);
    if0.clk_div = 1'b0;
    rstn = 1'b1;
    repeat (2) @(negedge clk_in);

    // err_cnt saturation with 300 ratio-4 periods
    ne0 = nerr;
    repeat (300) drv(2, 2);
    chk("sat_ecnt", 32'(if0.err_cnt), 255);
    chk("sat_nerr", 32'(nerr - ne0), 299);
    chk("sat_per", 32'(if0.period), 4);

    // period saturation on the TIMEOUT=255 instance
    if0.en = 1'b0;
    if1.en = 1'b1;
    repeat (2) @(negedge clk_in);
    repeat (3) drv1(128, 128);
    chk("psat_per", 32'(if1.period), 255);
    chk("psat_high", 32'(if1.high_time), 128);
    chk("psat_no_to", 32'(if1.timeout), 0);
    chk("psat_ecnt", 32'(if1.err_cnt), 2);
    drv1(150, 150);
    chk("psat_to", 32'(if1.timeout), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
